// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack instruction-memory port, valid/ready decode port.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect traps into a sticky FAULT state).
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_fault
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
`endif

    state_t      state;
    logic [31:0] pc;
    logic        discard;
    logic [31:0] target;
    logic        redirect_take;

`ifdef MISALIGN_TRAP_EN
    logic redirect_trap;
    logic fault_q;

    assign target        = redirect_target;
    assign redirect_trap = redirect_valid & (|redirect_target[1:0]);
    assign redirect_take = redirect_valid & ~redirect_trap;
    assign fetch_fault   = fault_q;
`else
    // Low target bits are ignored, so redirects always land on a word boundary.
    logic unused_target_lsbs;

    assign unused_target_lsbs = ^redirect_target[1:0];
    assign target             = {redirect_target[31:2], 2'b00};
    assign redirect_take      = redirect_valid;
    assign fetch_fault        = 1'b0;
`endif

    assign instr_pc_plus4 = instr_pc + 32'd4;

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch reads the pre-edge values of pc, imem_addr and discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= 32'h0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
            discard     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            // A request already on the bus keeps imem_req high until its ack comes back.
            if (redirect_trap && state != S_FAULT) begin
                state       <= S_FAULT;
                fault_q     <= 1'b1;
                instr_valid <= 1'b0;
                discard     <= 1'b0;
                if (!(state == S_REQ && !imem_ack))
                    imem_req <= 1'b0;
            end else
`endif
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                    if (redirect_take) begin
                        pc        <= target;
                        imem_addr <= target;
                    end else begin
                        imem_addr <= pc;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        if (redirect_take) begin
                            pc        <= target;
                            imem_addr <= target;
                            discard   <= 1'b0;
                        end else if (discard) begin
                            imem_addr <= pc;
                            discard   <= 1'b0;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= imem_addr;
                            instr_valid <= 1'b1;
                            pc          <= imem_addr + 32'd4;
                            imem_req    <= 1'b0;
                            state       <= S_HOLD;
                        end
                    end else if (redirect_take) begin
                        // The old address stays on the bus; its data is dropped on ack.
                        pc      <= target;
                        discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_take) begin
                        instr_valid <= 1'b0;
                        pc          <= target;
                        imem_addr   <= target;
                        imem_req    <= 1'b1;
                        state       <= S_REQ;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        imem_addr   <= pc;
                        imem_req    <= 1'b1;
                        state       <= S_REQ;
                    end
                end
`ifdef MISALIGN_TRAP_EN
                S_FAULT: begin
                    if (imem_ack)
                        imem_req <= 1'b0;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
